pipe_hazard_scoreboard: RTL
===========================

// Module: pipe_hazard_scoreboard
// PURPOSE
//  Parametrised hazard/forwarding controller for the in-order pipeline.
//  Replaces the fixed HD + forwarding-unit pair.
//  Tracks in-flight register writers in a DEPTH-entry shift register:
//  EX=stage0, MEM=1, WB=DEPTH-1.
//  Outputs load-use stall, registered EX operand-forward selects for NUM_SRC sources,
//  branch-operand stall and a stall-cycle counter.
// PARAMETERS
//  REG_AW      5  register address width; address 0 is hardwired zero
//  NUM_SRC     2  source operands per instruction
//  DEPTH       3  post-ID stages holding results (>=2)
//  LOAD_STAGE  2  first stage index whose load result is forwardable (1..DEPTH-1)
//  CNT_W      32  stall counter width
// PORTS
//  clk_i          in   1               clock, rising edge
//  rst_i          in   1               async reset, active-low
//  hold_i         in   1               global freeze (memory wait); tracker does not advance
//  flush_i        in   1               ID instruction is wrong-path (taken branch/jump)
//  id_valid_i     in   1               ID holds a real instruction
//  id_src_i       in   NUM_SRC*REG_AW  source register addresses, src0 in LSBs
//  id_src_used_i  in   NUM_SRC         source actually read
//  id_dst_i       in   REG_AW          destination register
//  id_wr_en_i     in   1               instruction writes id_dst_i
//  id_is_load_i   in   1               result available only at LOAD_STAGE
//  id_is_branch_i in   1               operands consumed in ID (no ID forwarding)
//  stall_o        out  1               hold PC and IF/ID, insert EX bubble (combinational)
//  fwd_sel_o      out  NUM_SRC*SW      per-source EX select, SW=$clog2(DEPTH); 0=regfile, k=stage k
//  stall_cnt_o    out  CNT_W           stall cycles since reset, saturating
// BEHAVIOUR
//  - Reset (rst_i=0, async): all entries invalid, fwd_sel_o=0, stall_cnt_o=0, stall_o=0.
//  - Entry fields: valid, dst, is_load. Inserted only if id_valid_i & id_wr_en_i & id_dst_i!=0.
//  - Match: source j used, entry k in 0..DEPTH-2 valid, dst==src_j.
//    Youngest (lowest k) match only.
//    Stage DEPTH-1 is never matched; the regfile writes first in WB.
//  - Availability: avail = LOAD_STAGE if is_load else 1.
//  - Load-use stall: youngest match at k with k+1 < avail.
//  - Branch stall: id_is_branch_i and any match at k<=DEPTH-2.
//  - stall_o = id_valid_i & ~flush_i & ~hold_i & (load-use | branch stall).
//  - Flush takes priority over stall; flush with stall in the same cycle gives stall_o=0.
//  - Each edge with hold_i=0: entries shift k->k+1; entry DEPTH-1 drops.
//    Stage 0 gets a bubble (valid=0) if stall_o | flush_i | ~id_valid_i,
//    otherwise the ID instruction.
//  - fwd_sel_o (1-cycle latency, valid while consumer is in EX):
//    per source, youngest match k -> k+1; no match -> 0.
//    Forced 0 on bubble insertion.
//  - hold_i=1: entries, fwd_sel_o and stall_cnt_o frozen; stall_o=0.
//  - stall_cnt_o: +1 on each edge with stall_o=1; saturates at all-ones.
//  - Reset mid-operation: all in-flight entries are discarded immediately.
//    The next instruction sees no hazards.
// STRUCTURE
//  - pipe_pkg: REG_AW default, SW helper function, scoreboard entry struct
//    (valid/dst/is_load), FWD_REGFILE=0 constant.
//  - One sub-module, hazard_src_match: one source vs DEPTH-1 entries ->
//    {hit, youngest k, too_early}. Instantiated NUM_SRC times via generate.
//  - Top keeps the shift register, stall OR-reduce, fwd registers and counter.
// TESTING
//  1 rst_i low mid-stream with 2 loads in flight -> stall_o=0, fwd_sel_o=0, stall_cnt_o=0;
//    next dependent op sees no stall.
//  2 add r3 then sub r5,r3,r1 back-to-back -> no stall; sub in EX has fwd_sel[src0]=1.
//  3 lw r4 then add r6,r4,r4 -> stall_o=1 exactly 1 cycle, bubble in EX;
//    then fwd_sel both=2, stall_cnt_o=1.
//  4 add r5; add r5; or r7,r5,r0 -> fwd_sel[src0]=1 (youngest), src1=0 (r0 never matched).
//  5 lw r4 then beq r4,r2 -> stall_o=2 cycles.
//    Same case with flush_i=1 on the first of them -> stall_o=0, bubble inserted, counter unchanged.
//  6 hold_i=1 for 3 cycles during a load-use stall -> state frozen;
//    after release stall_o=1 for 1 cycle. DEPTH=5, LOAD_STAGE=3: lw then use -> 2 stall cycles, fwd_sel=3.

Source files
------------

// File: rtl/pipe_hazard_scoreboard_pkg.sv
// Shared types and helpers for the pipeline hazard scoreboard.
// Entries store destination addresses zero-extended to ENTRY_AW bits.
package pipe_pkg;

  localparam int REG_AW_DEFAULT = 5;
  localparam int ENTRY_AW       = 8;
  localparam int FWD_REGFILE    = 0;

  typedef struct packed {
    logic                valid;
    logic [ENTRY_AW-1:0] dst;
    logic                is_load;
  } sb_entry_t;

  function automatic int sel_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pipe_hazard_scoreboard_hazard_src_match.sv
// Compares one ID source operand against the matchable scoreboard entries.
// It reports the youngest hit and whether that producer's result is still too young to forward.
module hazard_src_match
  import pipe_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEFAULT,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SW         = sel_width(DEPTH)
) (
  input  logic [REG_AW-1:0]          i_src,
  input  logic                       i_used,
  input  sb_entry_t [DEPTH-2:0]      i_entries,
  output logic                       o_hit,
  output logic [SW-1:0]              o_k,
  output logic                       o_too_early
);

  // Scan from oldest to youngest so the youngest matching producer wins.
  always_comb begin
    o_hit       = 1'b0;
    o_k         = '0;
    o_too_early = 1'b0;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      if (i_used && i_entries[k].valid && (i_entries[k].dst == ENTRY_AW'(i_src))) begin
        o_hit       = 1'b1;
        o_k         = SW'(k);
        o_too_early = i_entries[k].is_load && ((k + 1) < LOAD_STAGE);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard and forwarding controller for the in-order pipeline.
// It produces the load-use and branch stalls, the registered EX forward selects, and a stall counter.
module pipe_hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEFAULT,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 32,
  localparam int SW        = sel_width(DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      hold_i,
  input  logic                      flush_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_i,
  input  logic [NUM_SRC-1:0]        id_src_used_i,
  input  logic [REG_AW-1:0]         id_dst_i,
  input  logic                      id_wr_en_i,
  input  logic                      id_is_load_i,
  input  logic                      id_is_branch_i,
  output logic                      stall_o,
  output logic [NUM_SRC*SW-1:0]     fwd_sel_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  // The WB stage gets no slot because the register file write already covers it.
  sb_entry_t [DEPTH-2:0]     r_sb;
  logic [NUM_SRC*SW-1:0]     r_fwd_sel;
  logic [CNT_W-1:0]          r_stall_cnt;

  sb_entry_t [DEPTH-2:0]     w_sb_next;
  sb_entry_t                 w_ins;
  logic [NUM_SRC-1:0]        w_hit;
  logic [NUM_SRC-1:0]        w_early;
  logic [NUM_SRC*SW-1:0]     w_k;
  logic [NUM_SRC*SW-1:0]     w_fwd_next;
  logic                      w_stall;
  logic                      w_bubble;

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    hazard_src_match #(
      .REG_AW     (REG_AW),
      .DEPTH      (DEPTH),
      .LOAD_STAGE (LOAD_STAGE),
      .SW         (SW)
    ) u_match (
      .i_src       (id_src_i[j*REG_AW +: REG_AW]),
      .i_used      (id_src_used_i[j]),
      .i_entries   (r_sb),
      .o_hit       (w_hit[j]),
      .o_k         (w_k[j*SW +: SW]),
      .o_too_early (w_early[j])
    );
  end

  assign w_stall  = id_valid_i & ~flush_i & ~hold_i &
                    ((|w_early) | (id_is_branch_i & (|w_hit)));
  assign w_bubble = w_stall | flush_i | ~id_valid_i;

  always_comb begin
    w_ins         = '0;
    w_ins.valid   = ~w_bubble & id_wr_en_i & (id_dst_i != '0);
    w_ins.dst     = ENTRY_AW'(id_dst_i);
    w_ins.is_load = id_is_load_i;
    w_sb_next     = r_sb;
    for (int k = DEPTH - 2; k > 0; k--) begin
      w_sb_next[k] = r_sb[k-1];
    end
    w_sb_next[0]  = w_ins;
  end

  // A producer found at stage k will be one stage further along when the consumer reaches EX.
  always_comb begin
    w_fwd_next = {NUM_SRC{SW'(FWD_REGFILE)}};
    if (!w_bubble) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (w_hit[j]) begin
          w_fwd_next[j*SW +: SW] = w_k[j*SW +: SW] + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sb        <= '0;
      r_fwd_sel   <= '0;
      r_stall_cnt <= '0;
    end else if (!hold_i) begin
      r_sb      <= w_sb_next;
      r_fwd_sel <= w_fwd_next;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_o     = w_stall;
  assign fwd_sel_o   = r_fwd_sel;
  assign stall_cnt_o = r_stall_cnt;

endmodule
